// File: rtl/ahb_smem_slave.sv
// AHB-Lite slave for the SMEM region: byte-lane writes through a one-deep pending buffer, registered reads with write forwarding.
// Optional: define AHB_SMEM_ERR_RESP_EN to give misaligned or oversized accesses a two-cycle ERROR response.
module ahb_smem_slave #(
    parameter int MEM_AW   = 15,
    parameter int WAIT_CYC = 0
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_b,
    input  logic        pad_smem_hsel,
    input  logic [31:0] pad_smem_haddr,
    input  logic [1:0]  pad_smem_htrans,
    input  logic        pad_smem_hwrite,
    input  logic [2:0]  pad_smem_hsize,
    input  logic [1:0]  pad_smem_hburst,
    input  logic [3:0]  pad_smem_hprot,
    input  logic [31:0] pad_smem_hwdata,
    input  logic        pad_smem_hready_in,
    output logic        smem_pad_hready,
    output logic [1:0]  smem_pad_hresp,
    output logic [31:0] smem_pad_hrdata
);
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t            state;
    logic              hready_reg;
    logic [1:0]        hresp_reg;
    logic [3:0]        wait_cnt;
    logic              cur_write;
    logic [MEM_AW-1:0] cur_idx;
    logic [3:0]        cur_mask;
    logic              pend_valid;
    logic [MEM_AW-1:0] pend_idx;
    logic [3:0]        pend_mask;
    logic [31:0]       pend_data;
    logic [3:0]        fwd_mask, fwd_mask_next;
    logic [31:0]       fwd_data, fwd_data_next;
    logic [31:0]       mem_rd;
    logic [31:0]       rd_merged;
    logic              can_accept, accept;
    logic [MEM_AW-1:0] acc_idx;
    logic [3:0]        acc_mask;
    logic              hit_cur, hit_pend;
    logic              unused;

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    assign unused = ^{pad_smem_hburst, pad_smem_hprot, pad_smem_haddr[31:MEM_AW+2]};

    assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept     = can_accept && pad_smem_hsel && pad_smem_htrans[1] && pad_smem_hready_in;
    assign acc_idx    = pad_smem_haddr[MEM_AW+1:2];

    // Lane mask also performs the natural-alignment masking of the low address bits.
    always_comb begin
        acc_mask = 4'b1111;
        case (pad_smem_hsize)
            3'd0:    acc_mask = 4'b0001 << pad_smem_haddr[1:0];
            3'd1:    acc_mask = pad_smem_haddr[1] ? 4'b1100 : 4'b0011;
            default: acc_mask = 4'b1111;
        endcase
    end

`ifdef AHB_SMEM_ERR_RESP_EN
    logic acc_illegal;
    assign acc_illegal = (pad_smem_hsize > 3'd2) ||
                         ((pad_smem_hsize == 3'd1) && pad_smem_haddr[0]) ||
                         ((pad_smem_hsize == 3'd2) && (pad_smem_haddr[1:0] != 2'b00));
`endif

    // A read accepted now may overlap the data phase of a write (hwdata on the bus) and a
    // pending buffer that commits on this same edge; the in-flight write is the newest.
    assign hit_cur  = (state == ST_DATA) && cur_write && (cur_idx == acc_idx);
    assign hit_pend = pend_valid && (pend_idx == acc_idx);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign fwd_mask_next[gi]         = (hit_cur && cur_mask[gi]) || (hit_pend && pend_mask[gi]);
        assign fwd_data_next[8*gi +: 8]  = (hit_cur && cur_mask[gi]) ? pad_smem_hwdata[8*gi +: 8]
                                                                     : pend_data[8*gi +: 8];
        assign rd_merged[8*gi +: 8]      = fwd_mask[gi] ? fwd_data[8*gi +: 8] : mem_rd[8*gi +: 8];
    end

    always_ff @(posedge cpu_clk) begin
        if (accept) begin
            mem_rd <= mem[acc_idx];
        end
        for (int i = 0; i < 4; i++) begin
            if (pend_valid && pend_mask[i]) begin
                mem[pend_idx][8*i +: 8] <= pend_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            state      <= ST_IDLE;
            hready_reg <= 1'b1;
            hresp_reg  <= 2'b00;
            wait_cnt   <= 4'd0;
            cur_write  <= 1'b0;
            cur_idx    <= '0;
            cur_mask   <= 4'b0000;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_mask  <= 4'b0000;
            pend_data  <= 32'd0;
            fwd_mask   <= 4'b0000;
            fwd_data   <= 32'd0;
        end else begin
            pend_valid <= 1'b0;
            if ((state == ST_DATA) && cur_write) begin
                pend_valid <= 1'b1;
                pend_idx   <= cur_idx;
                pend_mask  <= cur_mask;
                pend_data  <= pad_smem_hwdata;
            end

            case (state)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept) begin
                        cur_idx   <= acc_idx;
                        cur_mask  <= acc_mask;
                        cur_write <= pad_smem_hwrite;
                        fwd_mask  <= fwd_mask_next;
                        fwd_data  <= fwd_data_next;
                        hresp_reg <= 2'b00;
`ifdef AHB_SMEM_ERR_RESP_EN
                        if (acc_illegal) begin
                            state      <= ST_ERR1;
                            hready_reg <= 1'b0;
                            hresp_reg  <= 2'b01;
                            cur_write  <= 1'b0;
                        end else
`endif
                        if (WAIT_CYC > 0) begin
                            state      <= ST_WAIT;
                            wait_cnt   <= 4'(WAIT_CYC - 1);
                            hready_reg <= 1'b0;
                        end else begin
                            state      <= ST_DATA;
                            hready_reg <= 1'b1;
                        end
                    end else begin
                        state      <= ST_IDLE;
                        hready_reg <= 1'b1;
                        hresp_reg  <= 2'b00;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state      <= ST_DATA;
                        hready_reg <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state      <= ST_ERR2;
                    hready_reg <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    hready_reg <= 1'b1;
                    hresp_reg  <= 2'b00;
                end
            endcase
        end
    end

    assign smem_pad_hready = hready_reg;
    assign smem_pad_hresp  = hresp_reg;
    assign smem_pad_hrdata = ((state == ST_DATA) && !cur_write) ? rd_merged : 32'd0;

endmodule

// File: tb/tb_ahb_smem_slave.sv
// Directed bench for ahb_smem_slave: three instances (0, 1 and 3 wait states) driven by a pipelined AHB master task.
module tb_ahb_smem_slave;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        hsel_b = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [1:0]  hburst = 2'b01;
    logic [3:0]  hprot = 4'b0011;
    logic [31:0] hwdata = 32'd0;
    int          sel = 0;

    logic        rdy  [3];
    logic [1:0]  resp [3];
    logic [31:0] rdat [3];
    logic        hready_in;
    logic        cur_rdy;
    logic [1:0]  cur_resp;
    logic [31:0] cur_rdat;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign cur_rdy   = (sel == 2) ? rdy[2]  : (sel == 1) ? rdy[1]  : rdy[0];
    assign cur_resp  = (sel == 2) ? resp[2] : (sel == 1) ? resp[1] : resp[0];
    assign cur_rdat  = (sel == 2) ? rdat[2] : (sel == 1) ? rdat[1] : rdat[0];
    assign hready_in = cur_rdy;

    ahb_smem_slave #(.MEM_AW(15), .WAIT_CYC(0)) u_dut_w0 (
        .cpu_clk(clk), .cpu_rst_b(rst_b), .pad_smem_hsel(hsel_b && (sel == 0)),
        .pad_smem_haddr(haddr), .pad_smem_htrans(htrans), .pad_smem_hwrite(hwrite),
        .pad_smem_hsize(hsize), .pad_smem_hburst(hburst), .pad_smem_hprot(hprot),
        .pad_smem_hwdata(hwdata), .pad_smem_hready_in(hready_in),
        .smem_pad_hready(rdy[0]), .smem_pad_hresp(resp[0]), .smem_pad_hrdata(rdat[0]));

    ahb_smem_slave #(.MEM_AW(15), .WAIT_CYC(1)) u_dut_w1 (
        .cpu_clk(clk), .cpu_rst_b(rst_b), .pad_smem_hsel(hsel_b && (sel == 1)),
        .pad_smem_haddr(haddr), .pad_smem_htrans(htrans), .pad_smem_hwrite(hwrite),
        .pad_smem_hsize(hsize), .pad_smem_hburst(hburst), .pad_smem_hprot(hprot),
        .pad_smem_hwdata(hwdata), .pad_smem_hready_in(hready_in),
        .smem_pad_hready(rdy[1]), .smem_pad_hresp(resp[1]), .smem_pad_hrdata(rdat[1]));

    ahb_smem_slave #(.MEM_AW(15), .WAIT_CYC(3)) u_dut_w3 (
        .cpu_clk(clk), .cpu_rst_b(rst_b), .pad_smem_hsel(hsel_b && (sel == 2)),
        .pad_smem_haddr(haddr), .pad_smem_htrans(htrans), .pad_smem_hwrite(hwrite),
        .pad_smem_hsize(hsize), .pad_smem_hburst(hburst), .pad_smem_hprot(hprot),
        .pad_smem_hwdata(hwdata), .pad_smem_hready_in(hready_in),
        .smem_pad_hready(rdy[2]), .smem_pad_hresp(resp[2]), .smem_pad_hrdata(rdat[2]));

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          waits;
        logic        err;
    } op_t;

    op_t ops[$];

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void add(input logic [1:0] trans, input logic write, input logic [31:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                input logic [31:0] exp, input int waits, input logic err);
        op_t o;
        o.trans = trans; o.write = write; o.addr = addr; o.size = size;
        o.wdata = wdata; o.exp = exp; o.waits = waits; o.err = err;
        ops.push_back(o);
    endfunction

    task automatic drive_addr(input int i);
        if (i < ops.size()) begin
            hsel_b = 1'b1;
            haddr  = ops[i].addr;
            htrans = ops[i].trans;
            hwrite = ops[i].write;
            hsize  = ops[i].size;
        end else begin
            hsel_b = 1'b0;
            htrans = T_IDLE;
            hwrite = 1'b0;
        end
    endtask

    // Pipelined master: the address phase of op a overlaps the data phase of op d.
    task automatic run_ops(input string name);
        int   a;
        int   d;
        int   waits;
        logic r;
        a = 0; d = -1; waits = 0;
        @(posedge clk); #1;
        drive_addr(0);
        while (1) begin
            @(negedge clk);
            r = cur_rdy;
            if (d >= 0) begin
                if (!r) begin
                    waits++;
                    check_eq($sformatf("%s[%0d].resp_wait", name, d), {30'd0, cur_resp}, {31'd0, ops[d].err});
                    if (waits > 40) begin
                        check_eq($sformatf("%s[%0d].timeout", name, d), 32'd1, 32'd0);
                        drive_addr(ops.size());
                        return;
                    end
                end else begin
                    $display("xfer %s[%0d] trans=%0d wr=%0d addr=%h rdata=%h resp=%0d waits=%0d",
                             name, d, ops[d].trans, ops[d].write, ops[d].addr, cur_rdat, cur_resp, waits);
                    check_eq($sformatf("%s[%0d].waits", name, d), waits, ops[d].waits);
                    check_eq($sformatf("%s[%0d].resp", name, d), {30'd0, cur_resp}, {31'd0, ops[d].err});
                    check_eq($sformatf("%s[%0d].rdata", name, d), cur_rdat, ops[d].exp);
                end
            end
            @(posedge clk); #1;
            if (r) begin
                d = (a < ops.size()) ? a : -1;
                a++;
                drive_addr(a);
                hwdata = (d >= 0) ? ops[d].wdata : 32'd0;
                waits = 0;
                if (d < 0) break;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset.hready", {31'd0, rdy[0]}, 32'd1);
        check_eq("reset.hresp", {30'd0, resp[0]}, 32'd0);
        check_eq("reset.hrdata", rdat[0], 32'd0);
        check_eq("reset.hready_w3", {31'd0, rdy[2]}, 32'd1);
        rst_b = 1'b1;

        // Zero-wait write then back-to-back reads: in-flight, pending-buffer and memory paths.
        sel = 0; ops.delete();
        add(T_NSEQ, 1'b1, 32'h6000_0010, 3'd2, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b0, 32'h6000_0010, 3'd2, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
        add(T_NSEQ, 1'b0, 32'h6000_0010, 3'd2, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
        add(T_IDLE, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b0, 32'h6000_0010, 3'd2, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
        run_ops("fwd");

        // Top word, aliased index 0, and read back through ignored upper address bits.
        ops.delete();
        add(T_NSEQ, 1'b1, 32'h6001_FFFC, 3'd2, 32'hA5A5_5A5A, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b1, 32'h6002_0000, 3'd2, 32'h0BAD_F00D, 32'd0, 0, 1'b0);
        add(T_IDLE, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        add(T_IDLE, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'h0BAD_F00D, 0, 1'b0);
        add(T_NSEQ, 1'b0, 32'h7FFF_FFFC, 3'd2, 32'd0, 32'hA5A5_5A5A, 0, 1'b0);
        run_ops("wrap");

        // Byte lanes then halfword overwrite.
        ops.delete();
        add(T_NSEQ, 1'b1, 32'h6000_0020, 3'd0, 32'h0000_0011, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b1, 32'h6000_0021, 3'd0, 32'h0000_2200, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b1, 32'h6000_0022, 3'd0, 32'h0033_0000, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b1, 32'h6000_0023, 3'd0, 32'h4400_0000, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b0, 32'h6000_0020, 3'd2, 32'd0, 32'h4433_2211, 0, 1'b0);
        add(T_NSEQ, 1'b1, 32'h6000_0022, 3'd1, 32'hABCD_0000, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b0, 32'h6000_0020, 3'd2, 32'd0, 32'hABCD_2211, 0, 1'b0);
        run_ops("lanes");

        // Three wait states: write, let it commit, read from memory.
        sel = 2; ops.delete();
        add(T_NSEQ, 1'b1, 32'h6000_0000, 3'd2, 32'h1357_9BDF, 32'd0, 3, 1'b0);
        add(T_IDLE, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        add(T_IDLE, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'h1357_9BDF, 3, 1'b0);
        add(T_NSEQ, 1'b1, 32'h6000_0040, 3'd2, 32'h1234_5678, 32'd0, 3, 1'b0);
        add(T_IDLE, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        add(T_IDLE, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        run_ops("wait3");

        // One wait state: INCR write burst then read burst, with BUSY and IDLE beats.
        sel = 1; ops.delete();
        add(T_NSEQ, 1'b1, 32'h6000_0100, 3'd2, 32'hA000_0001, 32'd0, 1, 1'b0);
        add(T_SEQ,  1'b1, 32'h6000_0104, 3'd2, 32'hA000_0002, 32'd0, 1, 1'b0);
        add(T_BUSY, 1'b1, 32'h6000_0108, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        add(T_SEQ,  1'b1, 32'h6000_0108, 3'd2, 32'hA000_0003, 32'd0, 1, 1'b0);
        add(T_SEQ,  1'b1, 32'h6000_010C, 3'd2, 32'hA000_0004, 32'd0, 1, 1'b0);
        add(T_NSEQ, 1'b0, 32'h6000_0100, 3'd2, 32'd0, 32'hA000_0001, 1, 1'b0);
        add(T_SEQ,  1'b0, 32'h6000_0104, 3'd2, 32'd0, 32'hA000_0002, 1, 1'b0);
        add(T_BUSY, 1'b0, 32'h6000_0108, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        add(T_SEQ,  1'b0, 32'h6000_0108, 3'd2, 32'd0, 32'hA000_0003, 1, 1'b0);
        add(T_SEQ,  1'b0, 32'h6000_010C, 3'd2, 32'd0, 32'hA000_0004, 1, 1'b0);
        add(T_IDLE, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        run_ops("burst");

        // Reset during the wait states of a write must discard it.
        sel = 2;
        @(posedge clk); #1;
        hsel_b = 1'b1; haddr = 32'h6000_0040; htrans = T_NSEQ; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel_b = 1'b0; htrans = T_IDLE; hwrite = 1'b0; hwdata = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("rst.in_wait", {31'd0, rdy[2]}, 32'd0);
        rst_b = 1'b0;
        #1;
        check_eq("rst.hready", {31'd0, rdy[2]}, 32'd1);
        check_eq("rst.hresp", {30'd0, resp[2]}, 32'd0);
        check_eq("rst.hrdata", rdat[2], 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        ops.delete();
        add(T_NSEQ, 1'b0, 32'h6000_0040, 3'd2, 32'd0, 32'h1234_5678, 3, 1'b0);
        run_ops("rst_read");

        // Misaligned word read.
        sel = 0; ops.delete();
`ifdef AHB_SMEM_ERR_RESP_EN
        add(T_NSEQ, 1'b0, 32'h6000_0002, 3'd2, 32'd0, 32'd0, 1, 1'b1);
        add(T_NSEQ, 1'b1, 32'h6000_0001, 3'd2, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
        add(T_NSEQ, 1'b1, 32'h6000_0000, 3'd3, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
        add(T_NSEQ, 1'b0, 32'h6000_0001, 3'd1, 32'd0, 32'd0, 1, 1'b1);
        add(T_IDLE, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'd0, 0, 1'b0);
        add(T_NSEQ, 1'b0, 32'h6000_0000, 3'd2, 32'd0, 32'h0BAD_F00D, 0, 1'b0);
`else
        add(T_NSEQ, 1'b0, 32'h6000_0002, 3'd2, 32'd0, 32'h0BAD_F00D, 0, 1'b0);
        add(T_NSEQ, 1'b0, 32'h6000_0003, 3'd1, 32'd0, 32'h0BAD_F00D, 0, 1'b0);
`endif
        run_ops("align");

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_smem_slave.md
Name: ahb_smem_slave

Overview:
AHB-Lite slave for the SMEM region (0x6000_0000–0x6001_FFFF). It sits directly downstream of the AHB delay FIFO and consumes its fifo_pad_* address/control outputs.
- Supports programmable wait states and byte/halfword/word writes.
- Forwards a pending write into a following read, so back-to-back reads return fresh data.
- Drives hready/hresp back toward the FIFO's pad_biu_hready input.

Parameters:
MEM_AW, 15, word-address width (2^15 words = 128 KB).
WAIT_CYC, 0, data-phase wait states inserted per NONSEQ/SEQ transfer (0..15).

Ports:
cpu_clk  input  1  clock
cpu_rst_b  input  1  reset, asynchronous, active-low
pad_smem_hsel  input  1  slave select from address decoder
pad_smem_haddr  input  32  address
pad_smem_htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
pad_smem_hwrite  input  1  1=write
pad_smem_hsize  input  3  0=byte, 1=half, 2=word
pad_smem_hburst  input  2  burst type (decoded for nothing; accepted)
pad_smem_hprot  input  4  protection (ignored)
pad_smem_hwdata  input  32  write data (data phase)
pad_smem_hready_in  input  1  bus-level hready (previous transfer complete)
smem_pad_hready  output  1  transfer done
smem_pad_hresp  output  2  00=OKAY, 01=ERROR
smem_pad_hrdata  output  32  read data

Behaviour:
- Reset: FSM in IDLE; hready=1, hresp=00, hrdata=0, pending-write valid=0. Memory contents are not reset.
- Accept (address phase): hsel && htrans[1] && hready_in. Latch the following:
  - hwrite
  - word index haddr[MEM_AW+1:2]
  - byte-lane mask derived from hsize/haddr[1:0]:
    - byte: lane haddr[1:0]
    - half: lanes {haddr[1],0}+0/1
    - word: all 4 lanes
    - hsize>2 is treated as word
- Unselected, IDLE or BUSY with hready_in=1: no state change; OKAY with zero wait.
- FSM:
  - IDLE: on accept → WAIT if WAIT_CYC>0, else DATA.
  - WAIT: load counter with WAIT_CYC−1 on entry; hready=0; decrement each cycle; at 0 → DATA.
  - DATA: hready=1, hresp=OKAY. If a new accept occurs in the same cycle → WAIT/DATA per WAIT_CYC (pipelined back-to-back); else → IDLE.
- Reads:
  - The memory read is issued at accept (registered) and rdata is held until the DATA cycle.
  - hrdata is valid only in the DATA cycle and is 0 otherwise.
  - Latency: WAIT_CYC+1 cycles from the address phase.
- Writes:
  - hwdata is sampled in the DATA cycle into the pending-write buffer (index, lane mask, data).
  - The buffer is committed to memory on the next clock.
- Forwarding: if a read is accepted while the pending write is valid and targets the same index, the returned data takes pending lanes from the buffer and the other lanes from memory.
- Simultaneous pending-write commit and new write accept are allowed; the commit completes first.
- Address wrap: bits above MEM_AW+1 are ignored; index 2^MEM_AW−1 followed by +4 wraps to index 0.
- Reset mid-transfer: FSM returns to IDLE and the pending write is discarded (no memory update).

Optional Feature:
Macro AHB_SMEM_ERR_RESP_EN.
- Defined: these accesses are flagged illegal and get the two-cycle AHB ERROR response:
  - misaligned: half with haddr[0]=1, or word with haddr[1:0]≠0
  - hsize>2
- ERROR response, skipping WAIT:
  - cycle 1: hready=0, hresp=01
  - cycle 2: hready=1, hresp=01
  - no memory write; hrdata=0
- Undefined: no error path. Low address bits are masked to natural alignment and hresp is constantly 00.

Test Plan:
1. WAIT_CYC=0: word write 0xDEADBEEF @0x6000_0010, then read same → hready never low; read returns 0xDEADBEEF one cycle after its address phase, via forwarding.
2. WAIT_CYC=3: read @0x6000_0000 → hready low exactly 3 cycles, then high with memory data and hresp=00.
3. Byte writes 0x11/0x22/0x33/0x44 to @0x6000_0020..23, then word read → 0x44332211; halfword write 0xABCD @0x6000_0022 then read → 0xABCD2211.
4. Back-to-back 4-beat INCR write then read burst, WAIT_CYC=1 → each beat 2 cycles; readback matches all 4 words; IDLE/BUSY beats give OKAY with zero wait.
5. Assert cpu_rst_b low during WAIT of a write → hready=1, hresp=00, hrdata=0 immediately; later read of that address returns old contents.
6. AHB_SMEM_ERR_RESP_EN: word read @0x6000_0002 → hready 0 then 1 with hresp=01 both cycles, memory unchanged. Without the macro → same access returns word @0x6000_0000 with OKAY.
